// File: rtl/present80_enc_core.sv
// Iterative PRESENT-80 block encryptor: one round per clock with on-the-fly key
// schedule, valid/ready handshakes on the request and ciphertext sides.
module present80_enc_core #(
  parameter int ROUNDS = 31,
  parameter int CNT_W  = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] plaintext,
  input  logic [79:0] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] ciphertext,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} state_e;

  state_e             state_q, state_d;
  logic [63:0]        blk_q, blk_d;
  logic [79:0]        key_q, key_d;
  logic [CNT_W-1:0]   rnd_q, rnd_d;
  logic [63:0]        ct_q, ct_d;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int n = 0; n < 16; n++) y[4*n +: 4] = sbox4(x[4*n +: 4]);
    return y;
  endfunction

  // Bit i lands on (16*i) mod 63; bit 63 is a fixed point.
  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 63; i++) y[6'((16*i) % 63)] = x[i];
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [79:0] key_update(input logic [79:0] k,
                                             input logic [CNT_W-1:0] r);
    logic [79:0] t;
    t          = {k[18:0], k[79:19]};
    t[79:76]   = sbox4(t[79:76]);
    t[19:15]   = t[19:15] ^ r[4:0];
    return t;
  endfunction

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    ct_d    = ct_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          blk_d   = plaintext;
          key_d   = key;
          rnd_d   = CNT_W'(1);
          state_d = RUN;
        end
      end
      RUN: begin
        blk_d = p_layer(sbox_layer(blk_q ^ key_q[79:16]));
        key_d = key_update(key_q, rnd_q);
        // Counter parks at the last round rather than wrapping.
        if (rnd_q == CNT_W'(ROUNDS)) state_d = FINAL;
        else                         rnd_d   = rnd_q + CNT_W'(1);
      end
      FINAL: begin
        ct_d    = blk_q ^ key_q[79:16];
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      blk_q   <= '0;
      key_q   <= '0;
      rnd_q   <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
      ct_q    <= ct_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign ciphertext = ct_q;

endmodule

// File: tb/tb_present80_enc_core.sv
// Randomized bench for present80_enc_core against a round-key-table PRESENT model
// and a cycle-level handshake model.
module tb_present80_enc_core;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [63:0] plaintext, ciphertext;
  logic [79:0] key;

  present80_enc_core #(.ROUNDS(31), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .key(key), .out_valid(out_valid),
    .out_ready(out_ready), .ciphertext(ciphertext), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] SBOX = 64'h21748FE3DA09B65C;  // nibble n holds S[n]
  // accept -> 32 edges to out_valid, one handshake edge, one idle edge
  localparam int SPACING = 32 + 1 + 1;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] s_fwd(input logic [3:0] x);
    return SBOX[4*int'(x) +: 4];
  endfunction

  function automatic logic [3:0] s_inv(input logic [3:0] x);
    logic [3:0] r;
    r = 4'h0;
    for (int j = 0; j < 16; j++) if (SBOX[4*j +: 4] == x) r = 4'(j);
    return r;
  endfunction

  function automatic int pdst(input int i);
    return (i == 63) ? 63 : (i * 16) % 63;
  endfunction

  function automatic logic [63:0] sub_all(input logic [63:0] s, input bit inv);
    logic [63:0] y;
    for (int n = 0; n < 16; n++) y[4*n +: 4] = inv ? s_inv(s[4*n +: 4]) : s_fwd(s[4*n +: 4]);
    return y;
  endfunction

  function automatic logic [63:0] perm(input logic [63:0] s, input bit inv);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) begin
      if (inv) y[i] = s[pdst(i)];
      else     y[pdst(i)] = s[i];
    end
    return y;
  endfunction

  // Round key n (1..32), derived from the user key by replaying the schedule.
  function automatic logic [63:0] rkey(input logic [79:0] k0, input int n);
    logic [79:0] k;
    k = k0;
    for (int i = 1; i < n; i++) begin
      k = {k[18:0], k[79:19]};
      k[79:76] = s_fwd(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(i);
    end
    return k[79:16];
  endfunction

  function automatic logic [63:0] enc_model(input logic [63:0] pt, input logic [79:0] k);
    logic [63:0] s;
    s = pt;
    for (int r = 1; r <= 31; r++) s = perm(sub_all(s ^ rkey(k, r), 1'b0), 1'b0);
    return s ^ rkey(k, 32);
  endfunction

  function automatic logic [63:0] dec_model(input logic [63:0] ct, input logic [79:0] k);
    logic [63:0] s;
    s = ct ^ rkey(k, 32);
    for (int r = 31; r >= 1; r--) s = sub_all(perm(s, 1'b1), 1'b1) ^ rkey(k, r);
    return s;
  endfunction

  // Cycle-level expectation of the handshake behaviour.
  bit          m_busy = 0, m_ovld = 0, chk_en = 0, rdy_n = 0;
  int          m_cnt = 0, cyc = 0;
  logic [63:0] m_exp = '0, m_ct = '0;
  int          d_acc[$];

  always @(posedge clk) begin
    cyc++;
    if (!rst && in_valid && rdy_n) d_acc.push_back(cyc);
    if (rst) begin
      m_busy = 0; m_ovld = 0; m_cnt = 0; m_ct = '0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1; m_cnt = 0; m_exp = enc_model(plaintext, key);
      end
    end else if (m_ovld) begin
      if (out_ready) begin m_ovld = 0; m_busy = 0; end
    end else begin
      m_cnt++;
      if (m_cnt == 32) begin m_ovld = 1; m_ct = m_exp; end
    end
  end

  always @(negedge clk) begin
    rdy_n = in_ready;
    if (chk_en) begin
      check("cyc_in_ready", in_ready, !m_busy);
      check("cyc_busy", busy, m_busy);
      check("cyc_out_valid", out_valid, m_ovld);
      check("cyc_ciphertext", ciphertext, m_ct);
    end
  end

  task automatic run_one(input logic [63:0] pt, input logic [79:0] k, input int stall,
                         output logic [63:0] ct, output int lat);
    @(negedge clk);
    check("req_in_ready", in_ready, 1'b1);
    in_valid = 1; plaintext = pt; key = k; out_ready = 0;
    @(negedge clk);
    in_valid = 0;
    plaintext = {$urandom, $urandom};
    key = {16'($urandom), $urandom, $urandom};
    lat = 0;
    while (!out_valid && lat < 100) begin
      in_valid = (lat == 5);
      @(negedge clk);
      lat++;
    end
    in_valid = 0;
    check("out_valid_seen", out_valid, 1'b1);
    ct = ciphertext;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom);
      @(negedge clk);
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_ciphertext", ciphertext, ct);
    end
    out_ready = 1; in_valid = 1'($urandom);
    @(negedge clk);
    out_ready = 0; in_valid = 0;
    check("post_in_ready", in_ready, 1'b1);
    check("post_busy", busy, 1'b0);
    check("post_out_valid", out_valid, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ct, pt;
    logic [79:0] k;
    int lat, w;

    rst = 1; in_valid = 0; out_ready = 0; plaintext = '0; key = '0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ciphertext", ciphertext, 64'h0);
    rst = 0;

    check("model_k0_p0", enc_model(64'h0, 80'h0), 64'h5579C1387B228445);
    check("model_k1_p0", enc_model(64'h0, {80{1'b1}}), 64'hE72C46C0F5945049);
    check("model_k0_p1", enc_model({64{1'b1}}, 80'h0), 64'hA112FFC72F68417B);
    check("model_k1_p1", enc_model({64{1'b1}}, {80{1'b1}}), 64'h3333DCD3213210D2);
    check("model_dec", dec_model(64'h5579C1387B228445, 80'h0), 64'h0);

    run_one(64'h0, 80'h0, 0, ct, lat);
    check("dut_k0_p0", ct, 64'h5579C1387B228445);
    check("latency", lat, 32);
    run_one(64'h0, {80{1'b1}}, 1, ct, lat);
    check("dut_k1_p0", ct, 64'hE72C46C0F5945049);
    run_one({64{1'b1}}, 80'h0, 2, ct, lat);
    check("dut_k0_p1", ct, 64'hA112FFC72F68417B);
    run_one({64{1'b1}}, {80{1'b1}}, 10, ct, lat);
    check("dut_k1_p1_stall", ct, 64'h3333DCD3213210D2);

    // Reset in the middle of the rounds discards the block.
    @(negedge clk);
    in_valid = 1; plaintext = {$urandom, $urandom}; key = {16'($urandom), $urandom, $urandom};
    @(negedge clk);
    in_valid = 0;
    repeat (14) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_ciphertext", ciphertext, 64'h0);
    repeat (40) @(negedge clk);
    run_one(64'h0, 80'h0, 0, ct, lat);
    check("after_rst_k0_p0", ct, 64'h5579C1387B228445);

    // Back-to-back requests with the consumer always ready.
    d_acc.delete();
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 3 * SPACING + 2; i++) begin
      plaintext = {$urandom, $urandom};
      key = {16'($urandom), $urandom, $urandom};
      @(negedge clk);
    end
    in_valid = 0;
    w = 0;
    while (busy && w < 100) begin @(negedge clk); w++; end
    check("b2b_drained", busy, 1'b0);
    out_ready = 0;
    check("b2b_accepts", (d_acc.size() >= 3), 1'b1);
    for (int i = 1; i < d_acc.size(); i++)
      check("b2b_spacing", d_acc[i] - d_acc[i-1], SPACING);

    // Random round trips through the inverse cipher.
    for (int n = 0; n < 1000; n++) begin
      pt = {$urandom, $urandom};
      k  = {16'($urandom), $urandom, $urandom};
      run_one(pt, k, int'($urandom_range(0, 2)), ct, lat);
      check("roundtrip", dec_model(ct, k), pt);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
